// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared constants for the pipeline hazard/stall sequencer: RV32I opcodes,
// sequencer states and the bundle of pipeline control outputs.
package hazard_stall_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        HSC_RUN       = 2'd0,
        HSC_DMEM_WAIT = 2'd1,
        HSC_IMEM_WAIT = 2'd2
    } hsc_state_t;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_flush;
        logic id_ex_bubble;
        logic pipe_hold;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_DEFAULT   = '{pc_write: 1'b1, if_id_write: 1'b1, if_flush: 1'b0, id_ex_bubble: 1'b0, pipe_hold: 1'b0};
    localparam pipe_ctrl_t CTRL_RESET     = '{pc_write: 1'b0, if_id_write: 1'b0, if_flush: 1'b1, id_ex_bubble: 1'b1, pipe_hold: 1'b0};
    localparam pipe_ctrl_t CTRL_FREEZE    = '{pc_write: 1'b0, if_id_write: 1'b0, if_flush: 1'b0, id_ex_bubble: 1'b0, pipe_hold: 1'b1};
    localparam pipe_ctrl_t CTRL_BRANCH    = '{pc_write: 1'b1, if_id_write: 1'b1, if_flush: 1'b1, id_ex_bubble: 1'b1, pipe_hold: 1'b0};
    localparam pipe_ctrl_t CTRL_LOAD_USE  = '{pc_write: 1'b0, if_id_write: 1'b0, if_flush: 1'b0, id_ex_bubble: 1'b1, pipe_hold: 1'b0};
    localparam pipe_ctrl_t CTRL_IMEM_WAIT = '{pc_write: 1'b0, if_id_write: 1'b1, if_flush: 1'b1, id_ex_bubble: 1'b0, pipe_hold: 1'b0};

    function automatic logic opc_uses_rs1(input logic [6:0] opc);
        return !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
    endfunction

    function automatic logic opc_uses_rs2(input logic [6:0] opc);
        return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_timeout_cnt.sv
// Clear/enable up-counter that saturates at all-ones instead of wrapping,
// with a flag while the count sits on a chosen terminal value.
module stall_timeout_cnt #(
    parameter int              WIDTH    = 8,
    parameter logic [WIDTH-1:0] TERMINAL = '1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

    assign tc = (count == TERMINAL);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer: same-cycle PC / IF/ID / ID/EX controls from state and
// hazard inputs, plus an instruction-fetch watchdog and a stall-cycle counter.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TMO_WIDTH      = 8,
    parameter int IMEM_TIMEOUT   = 200,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [6:0]                IF_ID_inst_opcode,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
    input  logic                      ID_EX_mem_read,
    input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
    input  logic                      EX_branch_taken,
    input  logic                      dmem_req,
    input  logic                      dmem_ready,
    input  logic                      imem_ready,
    output logic                      pc_write,
    output logic                      IF_ID_write,
    output logic                      IF_flush,
    output logic                      ID_EX_bubble,
    output logic                      pipe_hold,
    output logic                      imem_timeout,
    output logic [CNT_WIDTH-1:0]      stall_count
);

    localparam logic [TMO_WIDTH-1:0] TMO_TERMINAL = TMO_WIDTH'(IMEM_TIMEOUT - 1);

    hsc_state_t state;
    hsc_state_t next_state;
    pipe_ctrl_t ctrl;

    logic dmem_freeze;
    logic load_use_hit;
    logic take_branch;
    logic take_load_use;
    logic take_imem_wait;
    logic tmo_clr;
    logic tmo_tc;

    // The EX stage is frozen during a data-memory stall, so a pending taken
    // branch simply stays on EX_branch_taken until the first unfrozen cycle.
    assign dmem_freeze = dmem_req && !dmem_ready;

    assign load_use_hit = ID_EX_mem_read && (ID_EX_rd != '0) &&
                          (((ID_EX_rd == IF_ID_rs1) && opc_uses_rs1(IF_ID_inst_opcode)) ||
                           ((ID_EX_rd == IF_ID_rs2) && opc_uses_rs2(IF_ID_inst_opcode)));

    assign take_branch    = !dmem_freeze && EX_branch_taken;
    assign take_load_use  = !dmem_freeze && !EX_branch_taken && load_use_hit;
    assign take_imem_wait = !dmem_freeze && !EX_branch_taken && !load_use_hit && !imem_ready;

    always_comb begin
        ctrl       = CTRL_DEFAULT;
        next_state = HSC_RUN;
        if (reset) begin
            ctrl       = CTRL_RESET;
            next_state = HSC_RUN;
        end else if (dmem_freeze) begin
            ctrl       = CTRL_FREEZE;
            next_state = HSC_DMEM_WAIT;
        end else if (take_branch) begin
            ctrl       = CTRL_BRANCH;
            next_state = imem_ready ? HSC_RUN : HSC_IMEM_WAIT;
        end else if (take_load_use) begin
            ctrl       = CTRL_LOAD_USE;
            next_state = HSC_RUN;
        end else if (take_imem_wait) begin
            ctrl       = CTRL_IMEM_WAIT;
            next_state = HSC_IMEM_WAIT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HSC_RUN;
        end else begin
            state <= next_state;
        end
    end

    assign pc_write     = ctrl.pc_write;
    assign IF_ID_write  = ctrl.if_id_write;
    assign IF_flush     = ctrl.if_flush;
    assign ID_EX_bubble = ctrl.id_ex_bubble;
    assign pipe_hold    = ctrl.pipe_hold;

    // The watchdog count is always zero in RUN; it only needs clearing when a
    // wait state is left without a freeze or another fetch-wait cycle.
    assign tmo_clr = take_branch ||
                     (!dmem_freeze && !take_imem_wait && (state != HSC_RUN));

    stall_timeout_cnt #(
        .WIDTH    (TMO_WIDTH),
        .TERMINAL (TMO_TERMINAL)
    ) u_imem_wdog (
        .clk   (clk),
        .reset (reset),
        .clr   (tmo_clr),
        .en    (take_imem_wait),
        .tc    (tmo_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            imem_timeout <= 1'b0;
        end else if (take_imem_wait && tmo_tc) begin
            imem_timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (!pc_write && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_WIDTH'(1);
        end
    end

endmodule
